// File: rtl/op_eval_unit.sv
// -----------------------------------------------------------------------------
// op_eval_unit
// Registered evaluator for a fixed set of unsigned operators. Operands are
// captured on a rising clock edge; single-cycle operators complete in the
// accept cycle, while / and % run through an iterative restoring divider that
// produces one quotient bit per cycle, MSB first.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand/opcode valid
//   in_ready   unit can accept (high only in IDLE, low while in reset)
//   op_sel     opcode (0..13 legal, 14/15 flagged as bad_op)
//   a, b       operands, WIDTH bits, unsigned
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   result     result, zero-extended to 2*WIDTH
//   div_zero   / or % issued with b == 0 (qualified by out_valid)
//   bad_op     illegal opcode (qualified by out_valid)
// -----------------------------------------------------------------------------
module op_eval_unit #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         op_sel,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               div_zero,
   output logic               bad_op
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_q, state_d;
   logic               in_ready_q, in_ready_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   dvsr_q, dvsr_d;
   logic               is_mod_q, is_mod_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               div_zero_q, div_zero_d;
   logic               bad_op_q, bad_op_d;

   logic [2*WIDTH-1:0] op_res;
   logic               op_dz;
   logic               op_bad;

   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     rem_sub;
   logic               q_bit;
   logic [WIDTH-1:0]   rem_next;

   logic               accept;
   logic               needs_div;

   // Single-cycle operator results, evaluated straight from the input operands
   // so they can be registered on the accept edge.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the case leaves it unassigned and infers a latch.
      op_res = '0;
      op_dz  = 1'b0;
      op_bad = 1'b0;
      case (op_sel)
         4'd0:  op_res = (2*WIDTH)'(a) * (2*WIDTH)'(b);
         4'd1:  begin
                   op_res[WIDTH-1:0] = '1;        // divide-by-zero quotient
                   op_dz             = (b == '0);
                end
         4'd2:  op_res = (2*WIDTH)'(a) + (2*WIDTH)'(b);
         4'd3:  op_res[WIDTH-1:0] = a - b;
         4'd4:  begin
                   op_res[WIDTH-1:0] = a;         // divide-by-zero remainder
                   op_dz             = (b == '0);
                end
         4'd5:  op_res[0] = (a == '0);
         4'd6:  op_res[0] = (a != '0) && (b != '0);
         4'd7:  op_res[0] = (a != '0) || (b != '0);
         4'd8:  op_res[0] = (a < b);
         4'd9:  op_res[0] = (a > b);
         4'd10: op_res[0] = (a == b);
         4'd11: op_res[WIDTH-1:0] = ~b;
         4'd12: op_res[0] = ^b;
         4'd13: op_res[1:0] = (a != '0) ? 2'd1 : 2'd2;
         default: op_bad = 1'b1;
      endcase
   end

   // One restoring-division step. The remainder stays below the divisor, so
   // the shifted value is below twice the divisor and the borrow out of the
   // trial subtraction alone decides the quotient bit.
   always_comb begin
      rem_sh   = {rem_q, quot_q[WIDTH-1]};
      rem_sub  = rem_sh - {1'b0, dvsr_q};
      q_bit    = ~rem_sub[WIDTH];
      rem_next = q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   end

   // in_ready is registered, so it reads 0 during reset and rises on the
   // first clock after release.
   assign accept    = in_valid && in_ready_q;
   assign needs_div = ((op_sel == 4'd1) || (op_sel == 4'd4)) && (b != '0);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      dvsr_d     = dvsr_q;
      is_mod_d   = is_mod_q;
      result_d   = result_q;
      div_zero_d = div_zero_q;
      bad_op_d   = bad_op_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               div_zero_d = 1'b0;
               bad_op_d   = 1'b0;
               if (needs_div) begin
                  // result keeps its previous value until the divide lands.
                  state_d  = BUSY;
                  cnt_d    = CW'(WIDTH);
                  quot_d   = a;
                  rem_d    = '0;
                  dvsr_d   = b;
                  is_mod_d = op_sel[2];   // opcode 4 is %, opcode 1 is /
               end else begin
                  state_d    = DONE;
                  result_d   = op_res;
                  div_zero_d = op_dz;
                  bad_op_d   = op_bad;
               end
            end
         end
         BUSY: begin
            quot_d = {quot_q[WIDTH-2:0], q_bit};
            rem_d  = rem_next;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d  = DONE;
               result_d = is_mod_q ? (2*WIDTH)'(rem_next) : (2*WIDTH)'(quot_d);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
         cnt_q      <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         dvsr_q     <= '0;
         is_mod_q   <= 1'b0;
         result_q   <= '0;
         div_zero_q <= 1'b0;
         bad_op_q   <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every
         // register samples the pre-edge values, independent of statement order.
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         cnt_q      <= cnt_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         dvsr_q     <= dvsr_d;
         is_mod_q   <= is_mod_d;
         result_q   <= result_d;
         div_zero_q <= div_zero_d;
         bad_op_q   <= bad_op_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign div_zero  = div_zero_q;
   assign bad_op    = bad_op_q;

endmodule

// File: tb/tb_op_eval_unit.sv
// -----------------------------------------------------------------------------
// tb_op_eval_unit
// Directed bench for op_eval_unit (WIDTH=8). Inputs change and outputs are
// sampled 1 time unit after the rising edge. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_op_eval_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op_sel = 4'd0;
   logic [7:0]  a = 8'd0;
   logic [7:0]  b = 8'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] result;
   logic        div_zero;
   logic        bad_op;

   int total = 0;
   int bad   = 0;

   op_eval_unit #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sel    (op_sel),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .div_zero  (div_zero),
      .bad_op    (bad_op)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one operation, then wait (bounded) for out_valid. lat counts the
   // accept cycle as 1. rdy_seen records any in_ready high while waiting.
   task automatic start_op(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                           output int lat, output logic rdy_seen);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      op_sel   = op;
      a        = av;
      b        = bv;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat      = 1;
      rdy_seen = in_ready;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
         rdy_seen |= in_ready;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] av,
                        input logic [7:0] bv, input logic [15:0] exp_res, input int exp_lat,
                        input logic exp_dz, input logic exp_bad);
      int   lat;
      logic rdy_seen;
      start_op(op, av, bv, lat, rdy_seen);
      check({tag, "_lat"},   lat, exp_lat);
      check({tag, "_res"},   {16'd0, result}, {16'd0, exp_res});
      check({tag, "_dz"},    {31'd0, div_zero}, {31'd0, exp_dz});
      check({tag, "_bad"},   {31'd0, bad_op}, {31'd0, exp_bad});
      check({tag, "_rdy"},   {31'd0, rdy_seen}, 32'd0);
      consume();
      check({tag, "_drop"},  {31'd0, out_valid}, 32'd0);
   endtask

   // Logical/bitwise ops with a=0, b=8'hA5.
   logic [3:0]  l_op  [9] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
   logic [15:0] l_exp [9] = '{16'd1, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'h5A, 16'd0, 16'd2};

   initial begin
      logic seen_valid;
      int   lat;
      logic rdy_seen;

      // Reset state.
      #1;
      check("rst_in_ready",  {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result",    {16'd0, result}, 32'd0);
      check("rst_flags",     {30'd0, div_zero, bad_op}, 32'd0);
      #13 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_ready", {31'd0, in_ready}, 32'd1);

      // Wide arithmetic.
      do_op("mul_ff",  4'd0, 8'd255, 8'd255, 16'hFE01, 1, 1'b0, 1'b0);
      do_op("add_cy",  4'd2, 8'd255, 8'd1,   16'h0100, 1, 1'b0, 1'b0);
      do_op("sub_wrap", 4'd3, 8'd5,  8'd7,   16'h00FE, 1, 1'b0, 1'b0);

      // Reset in the middle of a divide: output cleared at once, never revived.
      in_valid = 1'b1; op_sel = 4'd1; a = 8'd200; b = 8'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("busy_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_valid",  {31'd0, out_valid}, 32'd0);
      check("midrst_result", {16'd0, result}, 32'd0);
      check("midrst_ready",  {31'd0, in_ready}, 32'd0);
      #2 rst_n = 1'b1;
      seen_valid = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         seen_valid |= out_valid;
      end
      check("midrst_no_stale", {31'd0, seen_valid}, 32'd0);
      check("midrst_ready_back", {31'd0, in_ready}, 32'd1);

      // Iterative divide.
      do_op("div_200_7", 4'd1, 8'd200, 8'd7,  16'd28, 9, 1'b0, 1'b0);
      do_op("mod_200_7", 4'd4, 8'd200, 8'd7,  16'd4,  9, 1'b0, 1'b0);
      do_op("div_255_16", 4'd1, 8'd255, 8'd16, 16'd15, 9, 1'b0, 1'b0);
      do_op("mod_255_16", 4'd4, 8'd255, 8'd16, 16'd15, 9, 1'b0, 1'b0);
      do_op("div_3_9",   4'd1, 8'd3,   8'd9,  16'd0,  9, 1'b0, 1'b0);

      // Divide by zero.
      do_op("div_zero", 4'd1, 8'd13, 8'd0, 16'h00FF, 1, 1'b1, 1'b0);
      do_op("mod_zero", 4'd4, 8'd13, 8'd0, 16'd13,   1, 1'b1, 1'b0);

      // Logical / reduction / select ops (flags must be cleared again).
      for (int i = 0; i < 9; i++)
         do_op($sformatf("lop%0d", l_op[i]), l_op[i], 8'd0, 8'hA5, l_exp[i], 1, 1'b0, 1'b0);
      do_op("sel_nz", 4'd13, 8'd4, 8'd0, 16'd1, 1, 1'b0, 1'b0);

      // Illegal opcodes.
      do_op("ill14", 4'd14, 8'd3, 8'd4, 16'd0, 1, 1'b0, 1'b1);
      do_op("ill15", 4'd15, 8'd3, 8'd4, 16'd0, 1, 1'b0, 1'b1);

      // Backpressure: result held while out_ready is low.
      start_op(4'd8, 8'd3, 8'd5, lat, rdy_seen);
      check("bp_lat", lat, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp_valid%0d", i),  {31'd0, out_valid}, 32'd1);
         check($sformatf("bp_result%0d", i), {16'd0, result}, 32'd1);
         check($sformatf("bp_ready%0d", i),  {31'd0, in_ready}, 32'd0);
      end
      consume();
      check("bp_drop",  {31'd0, out_valid}, 32'd0);
      check("bp_idle",  {31'd0, in_ready}, 32'd1);
      check("bp_hold",  {16'd0, result}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
